branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64: number of direct-mapped BTB/BHT entries (power of two).
REQ-002 SHALL have parameter IDX_W, default 6: log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port pc_if, input, 32: PC of the instruction being fetched this cycle.
REQ-006 SHALL have port pred_taken, output, 1: the fetched instruction is predicted as a taken branch.
REQ-007 SHALL have port pred_target, output, 32: next fetch PC, driven to the instruction cache address port (bits 31:2).
REQ-008 SHALL have port upd_en, input, 1: a branch resolved in EX this cycle.
REQ-009 SHALL have port pc_ex, input, 32: PC of the resolved branch.
REQ-010 SHALL have port taken_ex, input, 1: actual branch outcome.
REQ-011 SHALL have port target_ex, input, 32: actual branch target.
REQ-012 SHALL have port pred_taken_ex, input, 1: prediction piped from IF to EX with the branch.
REQ-013 SHALL have port pred_target_ex, input, 32: predicted target piped from IF to EX with the branch.
REQ-014 SHALL have port mispredict, output, 1: flush request for IF/ID.
REQ-015 SHALL have port redirect_pc, output, 32: corrected fetch PC, valid when mispredict=1.
REQ-016 SHALL have port br_cnt, output, 32: count of resolved branches.
REQ-017 SHALL have port mispred_cnt, output, 32: count of mispredictions.

Function
REQ-018 SHALL form index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2]; each entry holds valid, tag, 32-bit target and a 2-bit saturating counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-019 SHALL perform the lookup combinationally from pc_if with zero latency: hit = valid & tag match; pred_taken = hit & counter[1]; pred_target = pred_taken ? stored target : pc_if+4, with 32-bit wrap-around.
REQ-020 SHALL drive mispredict = upd_en & ((taken_ex != pred_taken_ex) | (taken_ex & target_ex != pred_target_ex)), combinationally in the same cycle.
REQ-021 SHALL drive redirect_pc = taken_ex ? target_ex : pc_ex+4.
REQ-022 SHALL, on upd_en with a hit at pc_ex, step the counter +1 if taken and -1 if not, saturating at 11 and 00, and overwrite the stored target with target_ex when taken.
REQ-023 SHALL, on upd_en with a miss and taken_ex=1, allocate the entry: valid=1, new tag, target=target_ex, counter=10, replacing any aliasing entry.
REQ-024 SHALL NOT allocate on upd_en with a miss and taken_ex=0.
REQ-025 SHALL apply table updates at the clock edge that ends the upd_en cycle; a same-cycle lookup of the same index SHALL return pre-update contents, with no forwarding.
REQ-026 SHALL increment br_cnt on every upd_en and mispred_cnt on every mispredict; both counters wrap modulo 2^32.

Reset
REQ-027 SHALL, when rst is high at a clock edge, clear all valid bits, set all counters to 01, zero br_cnt and mispred_cnt, and ignore upd_en in that cycle.
REQ-028 SHALL give the following values after reset until the first update: pred_taken=0, pred_target=pc_if+4; mispredict and redirect_pc remain combinational functions of the EX inputs.

Structure
REQ-029 SHALL place ENTRIES/IDX_W defaults, the counter encodings and the entry field widths in the shared package.
REQ-030 SHALL implement the 2-bit saturating counter step as one sub-module, bp_sat_counter; the remainder SHALL be a single module.

Verification
REQ-031 SHALL verify reset then first lookup: after reset, pc_if=0x1C -> pred_taken=0, pred_target=0x20.
REQ-032 SHALL verify mispredict and allocation: upd_en, pc_ex=0x1C, taken_ex=1, target_ex=0x14, pred_taken_ex=0 -> mispredict=1, redirect_pc=0x14; next cycle pc_if=0x1C -> pred_taken=1, pred_target=0x14; br_cnt=1, mispred_cnt=1.
REQ-033 SHALL verify hysteresis: after 3 more taken updates (counter 11), one not-taken -> still pred_taken=1; a second not-taken -> pred_taken=0, pred_target=0x20.
REQ-034 SHALL verify aliasing: taken update at pc_ex=0x11C, target 0x200 (same index 7) -> pc_if=0x11C hits with target 0x200; pc_if=0x1C misses (pred_target=0x20).
REQ-035 SHALL verify same-cycle conflict: update allocating 0x1C while pc_if=0x1C -> pred_taken=0 that cycle, 1 the next.
REQ-036 SHALL verify reset mid-run: rst asserted with upd_en=1 -> no allocation, counters read 0, all lookups miss.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared sizing, counter encodings and table entry field widths for the branch predictor.
// Latency: n/a; backpressure: n/a.
package branch_predictor_pkg;

  localparam int ENTRIES_DEF = 64;
  localparam int IDX_W_DEF   = 6;
  localparam int PC_W        = 32;

  // Entry field widths (tag width follows from the index width)
  localparam int VALID_W     = 1;
  localparam int TGT_W       = PC_W;
  localparam int CTR_W       = 2;
  localparam int TAG_W_DEF   = PC_W - IDX_W_DEF - 2;

  typedef enum logic [CTR_W-1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic int tag_w(input int idx_w);
    return PC_W - idx_w - 2;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter step: +1 on taken, -1 on not-taken, clamped at 11/00.
// Latency: combinational; backpressure: none.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST)
        nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT)
        nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB/BHT: zero-latency IF lookup, EX-stage resolve/update, branch and mispredict counters.
// Latency: lookup and mispredict combinational, table updates at the edge ending upd_en; backpressure: none.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_if,
  output logic          pred_taken,
  output logic [31:0]   pred_target,
  input  logic          upd_en,
  input  logic [31:0]   pc_ex,
  input  logic          taken_ex,
  input  logic [31:0]   target_ex,
  input  logic          pred_taken_ex,
  input  logic [31:0]   pred_target_ex,
  output logic          mispredict,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   br_cnt,
  output logic [31:0]   mispred_cnt
);

  localparam int TAG_W = tag_w(IDX_W);

  logic [VALID_W-1:0] valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TGT_W-1:0]   target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, hit_ex;
  logic [CTR_W-1:0] ctr_nxt;
  logic             upd_act;
  logic             unused_pc_lsb;

  assign idx_if = pc_if[IDX_W+1:2];
  assign tag_if = pc_if[31:IDX_W+2];
  assign idx_ex = pc_ex[IDX_W+1:2];
  assign tag_ex = pc_ex[31:IDX_W+2];
  assign unused_pc_lsb = ^{pc_if[1:0], pc_ex[1:0]};

  // Lookup reads the registered table only, so a same-cycle update is not forwarded
  assign hit_if      = valid_q[idx_if][0] && (tag_q[idx_if] == tag_if);
  assign pred_taken  = hit_if && ctr_q[idx_if][1];
  assign pred_target = pred_taken ? target_q[idx_if] : pc_if + 32'd4;

  assign hit_ex      = valid_q[idx_ex][0] && (tag_q[idx_ex] == tag_ex);
  assign mispredict  = upd_en && ((taken_ex != pred_taken_ex) ||
                                  (taken_ex && (target_ex != pred_target_ex)));
  assign redirect_pc = taken_ex ? target_ex : pc_ex + 32'd4;

  assign upd_act = upd_en && !rst;

  bp_sat_counter u_sat (
    .cur   (ctr_q[idx_ex]),
    .taken (taken_ex),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (upd_en) begin
      if (hit_ex) begin
        ctr_q[idx_ex] <= ctr_nxt;
      end else if (taken_ex) begin
        valid_q[idx_ex] <= 1'b1;
        ctr_q[idx_ex]   <= CTR_WT;
      end
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit
  always_ff @(posedge clk) begin
    if (upd_act && taken_ex) begin
      target_q[idx_ex] <= target_ex;
      if (!hit_ex)
        tag_q[idx_ex] <= tag_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_en)
        br_cnt <= br_cnt + 32'd1;
      if (mispredict)
        mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with an expected-result queue.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] pc_ex;
  logic        taken_ex;
  logic [31:0] target_ex;
  logic        pred_taken_ex;
  logic [31:0] pred_target_ex;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .pc_if          (pc_if),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_en         (upd_en),
    .pc_ex          (pc_ex),
    .taken_ex       (taken_ex),
    .target_ex      (target_ex),
    .pred_taken_ex  (pred_taken_ex),
    .pred_target_ex (pred_target_ex),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  typedef struct {
    logic        rst;
    logic        upd_en;
    logic [31:0] pc_ex;
    logic        taken_ex;
    logic [31:0] target_ex;
    logic        pte;
    logic [31:0] ptgt_ex;
    logic [31:0] pc_if;
    logic        e_misp;
    logic [31:0] e_redir;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic [31:0] e_br;
    logic [31:0] e_mc;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[20];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic u, input logic [31:0] pe,
                              input logic t, input logic [31:0] tg, input logic pt_ex,
                              input logic [31:0] ptg_ex, input logic [31:0] pi,
                              input logic em, input logic [31:0] er, input logic ept,
                              input logic [31:0] eptg, input logic [31:0] eb,
                              input logic [31:0] emc);
    vec_t v;
    v.rst = r; v.upd_en = u; v.pc_ex = pe; v.taken_ex = t; v.target_ex = tg;
    v.pte = pt_ex; v.ptgt_ex = ptg_ex; v.pc_if = pi;
    v.e_misp = em; v.e_redir = er; v.e_pt = ept; v.e_ptgt = eptg;
    v.e_br = eb; v.e_mc = emc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
      n_bad++;
    end
  endtask

  // Drive at the falling edge, compare 1ns later; the rising edge then commits
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; upd_en = v.upd_en; pc_ex = v.pc_ex; taken_ex = v.taken_ex;
    target_ex = v.target_ex; pred_taken_ex = v.pte; pred_target_ex = v.ptgt_ex;
    pc_if = v.pc_if;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk("mispredict",  n_vec, {31'd0, mispredict}, {31'd0, e.e_misp});
    chk("redirect_pc", n_vec, redirect_pc, e.e_redir);
    chk("pred_taken",  n_vec, {31'd0, pred_taken}, {31'd0, e.e_pt});
    chk("pred_target", n_vec, pred_target, e.e_ptgt);
    chk("br_cnt",      n_vec, br_cnt, e.e_br);
    chk("mispred_cnt", n_vec, mispred_cnt, e.e_mc);
    n_vec++;
  endtask

  initial begin
    rst = 1'b1; upd_en = 1'b0; pc_ex = '0; taken_ex = 1'b0; target_ex = '0;
    pred_taken_ex = 1'b0; pred_target_ex = '0; pc_if = '0;
    repeat (2) @(posedge clk);

    //          rst  upd pc_ex         tk  target        pte ptgt_ex      pc_if        misp redir         pt  ptgt          br  mc
    tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h1C,        0, 32'h4,        0, 32'h20,        0, 0);
    tbl[1]  = mk(0, 1, 32'h1C,       1, 32'h14,       0, 32'h20,       32'h1C,        1, 32'h14,       0, 32'h20,        0, 0);
    tbl[2]  = mk(0, 0, 32'h1C,       0, 32'h0,        0, 32'h0,        32'h1C,        0, 32'h20,       1, 32'h14,        1, 1);
    tbl[3]  = mk(0, 1, 32'h1C,       1, 32'h14,       1, 32'h14,       32'h1C,        0, 32'h14,       1, 32'h14,        1, 1);
    tbl[4]  = mk(0, 1, 32'h1C,       1, 32'h14,       1, 32'h14,       32'h1C,        0, 32'h14,       1, 32'h14,        2, 1);
    tbl[5]  = mk(0, 1, 32'h1C,       1, 32'h14,       1, 32'h14,       32'h1C,        0, 32'h14,       1, 32'h14,        3, 1);
    tbl[6]  = mk(0, 1, 32'h1C,       0, 32'h0,        1, 32'h14,       32'h1C,        1, 32'h20,       1, 32'h14,        4, 1);
    tbl[7]  = mk(0, 1, 32'h1C,       0, 32'h0,        1, 32'h14,       32'h1C,        1, 32'h20,       1, 32'h14,        5, 2);
    tbl[8]  = mk(0, 0, 32'h1C,       0, 32'h0,        0, 32'h0,        32'h1C,        0, 32'h20,       0, 32'h20,        6, 3);
    tbl[9]  = mk(0, 1, 32'h1C,       1, 32'h18,       0, 32'h20,       32'h1C,        1, 32'h18,       0, 32'h20,        6, 3);
    tbl[10] = mk(0, 1, 32'h1C,       1, 32'h14,       1, 32'h18,       32'h1C,        1, 32'h14,       1, 32'h18,        7, 4);
    tbl[11] = mk(0, 1, 32'h11C,      1, 32'h200,      0, 32'h120,      32'h1C,        1, 32'h200,      1, 32'h14,        8, 5);
    tbl[12] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h11C,       0, 32'h4,        1, 32'h200,       9, 6);
    tbl[13] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h1C,        0, 32'h4,        0, 32'h20,        9, 6);
    tbl[14] = mk(0, 1, 32'h40,       0, 32'h0,        0, 32'h44,       32'h40,        0, 32'h44,       0, 32'h44,        9, 6);
    tbl[15] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,        0, 32'h4,        0, 32'h44,       10, 6);
    tbl[16] = mk(0, 0, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        32'hFFFFFFFC,  0, 32'h0,        0, 32'h0,        10, 6);
    tbl[17] = mk(1, 1, 32'h80,       1, 32'h300,      0, 32'h84,       32'h11C,       1, 32'h300,      1, 32'h200,      10, 6);
    tbl[18] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h80,        0, 32'h4,        0, 32'h84,        0, 0);
    tbl[19] = mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h11C,       0, 32'h4,        0, 32'h120,       0, 0);

    for (int i = 0; i < 20; i++)
      apply(tbl[i]);

    // Burst of not-taken updates on an empty table: never allocates, every odd one mispredicts
    for (int i = 0; i < 20; i++) begin
      logic [31:0] pe;
      pe = {$urandom()} & 32'hFFFF_FFFC;
      apply(mk(0, 1, pe, 0, 32'h0, i[0], pe + 32'd4, pe,
               i[0], pe + 32'd4, 0, pe + 32'd4, i, i / 2));
    end
    apply(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h1C, 0, 32'h4, 0, 32'h20, 20, 10));

    // Back-to-back allocate then immediate hit on a different index
    apply(mk(0, 1, 32'h1000, 1, 32'hABC0, 0, 32'h1004, 32'h1000, 1, 32'hABC0, 0, 32'h1004, 20, 10));
    apply(mk(0, 1, 32'h1000, 1, 32'hABC0, 1, 32'hABC0, 32'h1000, 0, 32'hABC0, 1, 32'hABC0, 21, 11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
